// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the registered N:1 multiplexer family.
//   MODE_FIXED / MODE_SCAN : encoding of the 'mode' input
//   sel_width(n)           : width of a channel index for n channels (min 1)
// ---------------------------------------------------------------------------
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_SCAN  = 1'b1;

    // $clog2(2) is 1 already, but a single-channel caller would get 0.
    // Clamp so a channel index is never zero bits wide.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_ch_sel.sv
// ---------------------------------------------------------------------------
// mux_ch_sel
// Purely combinational N_CH:1 selector of WIDTH-bit words.
//   in_data  [N_CH*WIDTH] : packed words, channel k at [k*WIDTH +: WIDTH]
//   cur_ch   [SEL_W]      : channel index
//   sel_data [WIDTH]      : selected word (0 if cur_ch >= N_CH)
// ---------------------------------------------------------------------------
module mux_ch_sel
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 1,
    parameter int SEL_W = sel_width(N_CH)
) (
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      cur_ch,
    output logic [WIDTH-1:0]      sel_data
);

    // Compare-and-pick loop rather than an indexed part-select so an
    // out-of-range index yields a defined zero instead of X.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (cur_ch == SEL_W'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_nto1_reg.sv
// ---------------------------------------------------------------------------
// mux_nto1_reg
// N_CH-channel, WIDTH-bit multiplexer with a one-entry registered output and
// a fixed-select or round-robin scan channel pointer (cur_ch).
//
// Ports
//   clk, rst_n            : rising-edge clock, synchronous active-low reset
//   in_data  [N_CH*WIDTH] : producer words, channel k at [k*WIDTH +: WIDTH]
//   in_valid [N_CH]       : producer valids
//   in_ready [N_CH]       : producer readies (combinational, one-hot or zero)
//   mode                  : MODE_FIXED (0) or MODE_SCAN (1)
//   sel, sel_load         : load sel into cur_ch when sel < N_CH
//   out_data [WIDTH]      : registered word
//   out_ch   [SEL_W]      : channel that produced out_data
//   out_valid, out_ready  : consumer handshake
//   out_parity            : XOR of out_data, only with MUX_PARITY_EN defined
//
// Handshake: a word moves on any edge where valid and ready are both high.
// A valid, once raised, holds its data until accepted. The output stage
// accepts a new word when it is empty or being emptied in the same cycle,
// so back-to-back words flow at one per cycle.
// ---------------------------------------------------------------------------
module mux_nto1_reg
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 1,
    parameter int SEL_W = sel_width(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  sel_load,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
`ifdef MUX_PARITY_EN
    output logic                  out_parity,
`endif
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [SEL_W-1:0] cur_ch;
    logic [SEL_W-1:0] cur_ch_next;
    logic [WIDTH-1:0] sel_data;
    logic             cur_valid;
    logic             load_ok;
    logic             xfer;
    logic             sel_ok;

    mux_ch_sel #(
        .N_CH  (N_CH),
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_ch_sel (
        .in_data  (in_data),
        .cur_ch   (cur_ch),
        .sel_data (sel_data)
    );

    assign load_ok = !out_valid || out_ready;
    assign xfer    = rst_n && cur_valid && load_ok;
    assign sel_ok  = int'(sel) < N_CH;

    // Ready is gated by rst_n so producers never see a handshake in a
    // cycle whose edge is about to be consumed by reset.
    always_comb begin
        cur_valid = 1'b0;
        in_ready  = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (cur_ch == SEL_W'(k)) begin
                cur_valid   = in_valid[k];
                in_ready[k] = rst_n && load_ok;
            end
        end
    end

    // Scan advances past a channel after serving it or when it is idle,
    // but waits on a channel that is valid and blocked by a full output.
    // An in-range sel_load always wins over the advance.
    always_comb begin
        cur_ch_next = cur_ch;
        if (sel_load && sel_ok) begin
            cur_ch_next = sel;
        end else if (mode == MODE_SCAN && (xfer || !cur_valid)) begin
            cur_ch_next = (cur_ch == SEL_W'(N_CH - 1)) ? '0 : cur_ch + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_ch     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
`ifdef MUX_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            cur_ch <= cur_ch_next;
            if (xfer) begin
                out_valid  <= 1'b1;
                out_data   <= sel_data;
                out_ch     <= cur_ch;
`ifdef MUX_PARITY_EN
                out_parity <= ^sel_data;
`endif
            end else if (out_ready) begin
                // Word consumed with nothing behind it; data/ch stay as-is.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// ---------------------------------------------------------------------------
// tb_mux_nto1_reg
// Self-checking bench for mux_nto1_reg (N_CH=4, WIDTH=8) plus a small
// N_CH=6 instance for out-of-range sel handling. Build with +define+
// MUX_PARITY_EN to also check out_parity.
// ---------------------------------------------------------------------------
module tb_mux_nto1_reg;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;
    localparam int SEL_W = 2;
    localparam int W     = SEL_W + WIDTH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT (4 channels) ----------------
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic                  sel_load;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_valid;
    logic                  out_ready;
`ifdef MUX_PARITY_EN
    logic                  out_parity;
`endif

    mux_nto1_reg #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .sel_load  (sel_load),
        .out_data  (out_data),
        .out_ch    (out_ch),
`ifdef MUX_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // ---------------- DUT (6 channels, sel range) ----------------
    logic [6*WIDTH-1:0] u6_in_data;
    logic [5:0]         u6_in_valid;
    logic [5:0]         u6_in_ready;
    logic [2:0]         u6_sel;
    logic               u6_sel_load;
    logic [WIDTH-1:0]   u6_out_data;
    logic [2:0]         u6_out_ch;
    logic               u6_out_valid;
`ifdef MUX_PARITY_EN
    logic               u6_out_parity;
`endif

    mux_nto1_reg #(.N_CH(6), .WIDTH(WIDTH)) u6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (u6_in_data),
        .in_valid  (u6_in_valid),
        .in_ready  (u6_in_ready),
        .mode      (1'b0),
        .sel       (u6_sel),
        .sel_load  (u6_sel_load),
        .out_data  (u6_out_data),
        .out_ch    (u6_out_ch),
`ifdef MUX_PARITY_EN
        .out_parity(u6_out_parity),
`endif
        .out_valid (u6_out_valid),
        .out_ready (1'b1)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks which channel is being served and whether the output slot is
    // occupied; predicts ready and the word each transfer will deliver.
    int   m_cur   = 0;
    bit   m_valid = 1'b0;

    always begin : ref_model
        bit                load_ok;
        bit                xfer;
        bit                cur_v;
        logic [N_CH-1:0]   exp_rdy;
        @(negedge clk);
        #1;
        if (rst_n) check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        load_ok = !m_valid || out_ready;
        exp_rdy = (rst_n && load_ok) ? N_CH'(1 << m_cur) : '0;
        check("in_ready", {28'b0, in_ready}, {28'b0, exp_rdy});
        if (!rst_n) begin
            m_cur   = 0;
            m_valid = 1'b0;
            exp_q.delete();
        end else begin
            cur_v = in_valid[m_cur];
            xfer  = cur_v && load_ok;
            if (xfer) begin
                exp_q.push_back({SEL_W'(m_cur), in_data[m_cur*WIDTH +: WIDTH]});
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (sel_load && int'(sel) < N_CH) m_cur = int'(sel);
            else if (mode && (xfer || !cur_v)) m_cur = (m_cur + 1) % N_CH;
        end
    end

    // ---------------- monitor ----------------
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic [SEL_W-1:0] prev_ch;

    always begin : monitor
        logic [W-1:0] exp;
        @(negedge clk);
        if (rst_n && prev_stall) begin
            check("stall_data", {24'b0, out_data}, {24'b0, prev_data});
            check("stall_ch", {30'b0, out_ch}, {30'b0, prev_ch});
        end
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_word: got %0h expected none (t=%0t)", {out_ch, out_data}, $time);
            end else begin
                exp = exp_q.pop_front();
                check("out_word", {22'b0, out_ch, out_data}, {22'b0, exp});
`ifdef MUX_PARITY_EN
                check("out_parity", {31'b0, out_parity}, {31'b0, ^exp[WIDTH-1:0]});
`endif
            end
        end
        prev_stall = rst_n && out_valid && !out_ready;
        prev_data  = out_data;
        prev_ch    = out_ch;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic [N_CH-1:0] v, input logic m, input logic r,
                        input logic ld, input logic [SEL_W-1:0] s);
        in_valid  = v;
        mode      = m;
        out_ready = r;
        sel_load  = ld;
        sel       = s;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n       = 1'b0;
        in_data     = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        in_valid    = 4'b1111;
        mode        = 1'b0;
        sel         = '0;
        sel_load    = 1'b0;
        out_ready   = 1'b0;
        u6_in_data  = '0;
        u6_in_valid = '0;
        u6_sel      = '0;
        u6_sel_load = 1'b0;

        // Reset held for two edges with every channel valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", {24'b0, out_data}, 32'd0);
        check("rst_out_ch", {30'b0, out_ch}, 32'd0);
        check("rst_in_ready", {28'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Out-of-range sel on the 6-channel instance.
        u6_sel = 3'd5; u6_sel_load = 1'b1;
        step(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0);
        u6_sel_load = 1'b0;
        @(negedge clk);
        check("u6_sel5", {26'b0, u6_in_ready}, 32'b100000);
        u6_sel = 3'd7; u6_sel_load = 1'b1;
        step(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0);
        u6_sel_load = 1'b0;
        @(negedge clk);
        check("u6_sel7", {26'b0, u6_in_ready}, 32'b100000);

        // Fixed select of channel 2, continuous flow.
        step(4'b0000, 1'b0, 1'b1, 1'b1, 2'd2);
        repeat (6) step(4'b1111, 1'b0, 1'b1, 1'b0, 2'd0);

        // Backpressure: hold for 5 cycles, then release with no bubble.
        repeat (5) step(4'b1111, 1'b0, 1'b0, 1'b0, 2'd0);
        repeat (4) step(4'b1111, 1'b0, 1'b1, 1'b0, 2'd0);

        // Channel 0 word (A0) for the even-parity case.
        step(4'b0000, 1'b0, 1'b1, 1'b1, 2'd0);
        repeat (2) step(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0);

        // Scan with channels 1 and 3 active.
        step(4'b0000, 1'b0, 1'b1, 1'b1, 2'd0);
        repeat (10) step(4'b1010, 1'b1, 1'b1, 1'b0, 2'd0);

        // Scan stall on channel 3, then wrap to 0.
        step(4'b0000, 1'b0, 1'b0, 1'b1, 2'd3);
        step(4'b1000, 1'b0, 1'b1, 1'b0, 2'd0);
        repeat (3) step(4'b1000, 1'b1, 1'b0, 1'b0, 2'd0);
        repeat (3) step(4'b1000, 1'b1, 1'b1, 1'b0, 2'd0);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            in_data = $urandom;
            step(4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 7) == 0),
                 2'($urandom_range(0, 3)));
        end

        // Reset while a word is held under backpressure.
        repeat (2) step(4'b1111, 1'b0, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b0;
        step(4'b1111, 1'b0, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_stall_valid", {31'b0, out_valid}, 32'd0);

        // Drain.
        repeat (4) step(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0);
        @(negedge clk);
        #2;
        check("queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
